// File: rtl/uart_rx_frame_checker.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_checker
//
// Receive-side UART frame checker. Oversamples an already-synchronized serial
// line, qualifies the start bit, majority-votes each bit from three samples
// taken around the bit centre, deserializes the data LSB-first, and checks
// the optional parity bit and the stop bit. A good frame updates p_data with
// a one-cycle data_valid strobe; a bad frame raises par_err and/or stp_err
// for one cycle and leaves p_data untouched.
//
// Ports:
//   clk        UART oversampling clock
//   rst        asynchronous, active-high reset
//   rx_in      serial line, idle high
//   prescale   oversampling ratio (8, 16 or 32), captured at start detect
//   par_en     1 = frame carries a parity bit, captured at start detect
//   par_typ    0 = even, 1 = odd parity, captured at start detect
//   p_data     last good received word
//   data_valid one-cycle strobe, p_data updated
//   par_err    one-cycle strobe, parity mismatch
//   stp_err    one-cycle strobe, stop bit sampled low
//   busy       high while a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx_frame_checker #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [data_width-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int CW = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [5:0]            edge_cnt;
  logic [5:0]            cfg_prescale;
  logic                  cfg_par_en;
  logic                  cfg_par_typ;
  logic [CW-1:0]         bit_cnt;
  logic [data_width-1:0] shift_reg;
  logic [2:0]            samples;
  logic                  par_bad;

  logic [5:0]            half;
  logic [5:0]            last_edge;
  logic                  bit_end;
  logic                  majority;
  logic                  exp_parity;

  assign half      = cfg_prescale >> 1;
  assign last_edge = cfg_prescale - 6'd1;
  // Using >= rather than == means an illegal prescale (0 or 1) still ends
  // every bit period, so the FSM can never get stuck waiting for an edge
  // count it has already passed.
  assign bit_end   = (edge_cnt >= last_edge);
  assign majority  = (samples[0] & samples[1]) |
                     (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);
  // Same convention as the TX parity calculator: even -> XOR of the data,
  // odd -> its complement.
  assign exp_parity = cfg_par_typ ? ~^shift_reg : ^shift_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      edge_cnt     <= 6'd0;
      bit_cnt      <= '0;
      cfg_prescale <= 6'd16;
      cfg_par_en   <= 1'b0;
      cfg_par_typ  <= 1'b0;
      shift_reg    <= '0;
      samples      <= 3'b111;
      par_bad      <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state == IDLE) begin
        edge_cnt <= 6'd0;
        bit_cnt  <= '0;
        if (!rx_in) begin
          // This edge is edge 0 of the start bit, so the next one is edge 1.
          state        <= START;
          busy         <= 1'b1;
          edge_cnt     <= 6'd1;
          cfg_prescale <= prescale;
          cfg_par_en   <= par_en;
          cfg_par_typ  <= par_typ;
          samples      <= 3'b111;
        end
      end else begin
        // Three samples straddling the bit centre feed the 2-of-3 vote.
        if (edge_cnt == half - 6'd1) samples[0] <= rx_in;
        if (edge_cnt == half)        samples[1] <= rx_in;
        if (edge_cnt == half + 6'd1) samples[2] <= rx_in;

        if (bit_end) begin
          edge_cnt <= 6'd0;
        end else begin
          edge_cnt <= edge_cnt + 6'd1;
        end

        if (bit_end) begin
          case (state)
            START: begin
              if (!majority) begin
                state   <= DATA;
                bit_cnt <= '0;
                par_bad <= 1'b0;
              end else begin
                // A short low glitch on an idle line: drop it silently.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
            DATA: begin
              shift_reg <= {majority, shift_reg[data_width-1:1]};
              if (bit_cnt == LAST_BIT) begin
                state <= cfg_par_en ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
            PARITY: begin
              par_bad <= (majority != exp_parity);
              state   <= STOP;
            end
            STOP: begin
              if (majority && !par_bad) begin
                p_data     <= shift_reg;
                data_valid <= 1'b1;
              end
              stp_err <= ~majority;
              par_err <= par_bad;
              state   <= IDLE;
              busy    <= 1'b0;
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_checker
//
// Drives whole UART frames onto rx_in and compares every strobe the DUT
// raises (time, kind, p_data) against the frame-level expectations computed
// when the frame was generated.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  uart_rx_frame_checker #(.data_width(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count of rising edges seen so far; stable while clk is low.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic        valid;
    logic        perr;
    logic        serr;
    logic [7:0]  data;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         n_compared = 0;
  int         n_failed   = 0;
  logic [7:0] model_pdata = 8'h00;

  // Every strobe the DUT raises is logged with the cycle it was seen in.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (data_valid || par_err || stp_err)) begin
      e.cyc   = cyc;
      e.valid = data_valid;
      e.perr  = par_err;
      e.serr  = stp_err;
      e.data  = p_data;
      obs_q.push_back(e);
    end
  end

  function automatic string fmt_ev(input ev_t e);
    return $sformatf("cyc=%0d v=%b pe=%b se=%b d=%h", e.cyc, e.valid, e.perr, e.serr, e.data);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // Sends one frame and records what a correct receiver must report for it:
  // strobe exactly N*P cycles after the start bit is first seen.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                            input bit flip_par, input bit stop_bit, input int gbit, input int gk,
                            input bit scramble);
    logic bits[$];
    logic par;
    int   start;
    bit   bad_par;
    ev_t  e;
    bad_par = pen && flip_par;
    par = (ptyp ? ~^d : ^d) ^ flip_par;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(par);
    bits.push_back(logic'(stop_bit));
    start = 0;
    for (int j = 0; j < bits.size(); j++) begin
      for (int k = 0; k < p; k++) begin
        @(negedge clk);
        if (j == 0 && k == 0) begin
          start    = cyc;
          prescale = 6'(p);
          par_en   = pen;
          par_typ  = ptyp;
        end
        if (scramble && j == 1 && k == 0) begin
          prescale = 6'($urandom_range(8, 40));
          par_en   = 1'($urandom_range(0, 1));
          par_typ  = 1'($urandom_range(0, 1));
        end
        rx_in = bits[j] ^ (j == gbit && k == gk);
      end
    end
    e.cyc   = 32'(start + bits.size() * p);
    e.valid = stop_bit && !bad_par;
    e.perr  = bad_par;
    e.serr  = !stop_bit;
    if (e.valid) model_pdata = d;
    e.data  = model_pdata;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(negedge clk);
    n_compared += 5;
    if (p_data !== 8'h00) begin n_failed++; $display("[TB] FAIL reset_p_data: got %h, expected 00", p_data); end
    if (data_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_data_valid: got %b, expected 0", data_valid); end
    if (par_err !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_par_err: got %b, expected 0", par_err); end
    if (stp_err !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_stp_err: got %b, expected 0", stp_err); end
    if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    rst = 1'b0;
    idle(4);
    $display("[TB] reset checks done");
  endtask

  task automatic test_formats();
    obs_q.delete(); exp_q.delete();
    send_frame(8'hA5, 8, 1, 0, 0, 1, -1, 0, 0);
    idle(3);
    send_frame(8'h3C, 16, 1, 1, 0, 1, -1, 0, 0);
    idle(3);
    send_frame(8'hFF, 32, 0, 0, 0, 1, -1, 0, 0);
    idle(4);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin n_failed++; $display("[TB] FAIL formats_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin n_failed++; $display("[TB] FAIL formats_ev%0d: got %s, expected %s", i, fmt_ev(obs_q[i]), fmt_ev(exp_q[i])); end
    end
    $display("[TB] format checks done");
  endtask

  task automatic test_errors();
    obs_q.delete(); exp_q.delete();
    send_frame(8'h5A, 8, 1, 0, 1, 1, -1, 0, 0);
    idle(2);
    send_frame(8'h81, 8, 1, 0, 0, 0, -1, 0, 0);
    idle(2);
    send_frame(8'h42, 8, 1, 1, 1, 0, -1, 0, 0);
    idle(2);
    send_frame(8'h42, 8, 1, 0, 0, 1, -1, 0, 0);
    idle(4);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin n_failed++; $display("[TB] FAIL errors_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin n_failed++; $display("[TB] FAIL errors_ev%0d: got %s, expected %s", i, fmt_ev(obs_q[i]), fmt_ev(exp_q[i])); end
    end
    $display("[TB] error checks done");
  endtask

  task automatic test_glitch_majority();
    int c0;
    obs_q.delete(); exp_q.delete();
    prescale = 6'd8;
    par_en = 1'b0;
    @(negedge clk);
    c0 = cyc;
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b0;
    while (cyc < c0 + 7) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
    n_compared++;
    if (busy !== 1'b1) begin n_failed++; $display("[TB] FAIL glitch_busy_edge6: got %b, expected 1", busy); end
    @(negedge clk);
    rx_in = 1'b1;
    n_compared++;
    if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL glitch_busy_edge7: got %b, expected 0", busy); end
    idle(20);
    n_compared++;
    if (obs_q.size() != 0) begin n_failed++; $display("[TB] FAIL glitch_strobes: got %0d strobes, expected 0", obs_q.size()); end
    obs_q.delete();
    send_frame(8'h96, 16, 1, 0, 0, 1, 3, 8, 0);
    idle(2);
    send_frame(8'h6B, 8, 1, 1, 0, 1, 7, 4, 0);
    idle(4);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin n_failed++; $display("[TB] FAIL majority_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin n_failed++; $display("[TB] FAIL majority_ev%0d: got %s, expected %s", i, fmt_ev(obs_q[i]), fmt_ev(exp_q[i])); end
    end
    $display("[TB] glitch and majority checks done");
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    send_frame(8'h01, 8, 1, 0, 0, 1, -1, 0, 0);
    send_frame(8'h80, 8, 1, 0, 0, 1, -1, 0, 0);
    send_frame(8'h55, 8, 1, 0, 0, 1, -1, 0, 0);
    idle(4);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin n_failed++; $display("[TB] FAIL b2b_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin n_failed++; $display("[TB] FAIL b2b_ev%0d: got %s, expected %s", i, fmt_ev(obs_q[i]), fmt_ev(exp_q[i])); end
    end
    $display("[TB] back-to-back checks done");
  endtask

  // A line held low for two 8N1 frame times reports a stop error per frame.
  task automatic test_break();
    int  c0;
    ev_t e;
    obs_q.delete(); exp_q.delete();
    c0 = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (i == 0) begin
        c0 = cyc;
        prescale = 6'd8;
        par_en = 1'b0;
      end
      rx_in = 1'b0;
    end
    idle(6);
    for (int k = 1; k <= 2; k++) begin
      e.cyc = 32'(c0 + 80 * k);
      e.valid = 1'b0; e.perr = 1'b0; e.serr = 1'b1; e.data = model_pdata;
      exp_q.push_back(e);
    end
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin n_failed++; $display("[TB] FAIL break_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin n_failed++; $display("[TB] FAIL break_ev%0d: got %s, expected %s", i, fmt_ev(obs_q[i]), fmt_ev(exp_q[i])); end
    end
    $display("[TB] break checks done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    obs_q.delete(); exp_q.delete();
    d = 8'hC3;
    for (int k = 0; k < 43; k++) begin
      @(negedge clk);
      if (k == 0) begin prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; end
      rx_in = (k < 8) ? 1'b0 : d[(k - 8) / 8];
    end
    @(negedge clk);
    n_compared++;
    if (busy !== 1'b1) begin n_failed++; $display("[TB] FAIL midrst_busy_before: got %b, expected 1", busy); end
    rst = 1'b1;
    #1;
    n_compared += 3;
    if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
    if (p_data !== 8'h00) begin n_failed++; $display("[TB] FAIL midrst_p_data: got %h, expected 00", p_data); end
    if ({data_valid, par_err, stp_err} !== 3'b000) begin n_failed++; $display("[TB] FAIL midrst_strobes: got %b, expected 000", {data_valid, par_err, stp_err}); end
    model_pdata = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(5);
    send_frame(8'h9D, 8, 1, 0, 0, 1, -1, 0, 0);
    idle(4);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin n_failed++; $display("[TB] FAIL midrst_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin n_failed++; $display("[TB] FAIL midrst_ev%0d: got %s, expected %s", i, fmt_ev(obs_q[i]), fmt_ev(exp_q[i])); end
    end
    $display("[TB] mid-frame reset checks done");
  endtask

  // Random formats, data, errors, single-sample glitches, mid-frame config
  // changes and idle gaps (including none).
  task automatic test_random();
    int p;
    obs_q.delete(); exp_q.delete();
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      send_frame(8'($urandom), p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                 $urandom_range(0, 12), p / 2 - 1 + $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end
    idle(4);
    n_compared++;
    if (obs_q.size() != exp_q.size()) begin n_failed++; $display("[TB] FAIL random_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin n_failed++; $display("[TB] FAIL random_ev%0d: got %s, expected %s", i, fmt_ev(obs_q[i]), fmt_ev(exp_q[i])); end
    end
    $display("[TB] random checks done");
  endtask

  initial begin
    test_reset();
    test_formats();
    test_errors();
    test_glitch_majority();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
